// File: rtl/morty_wb_arbiter_if.sv
// ============================================================================
//  Module      : morty_wb_arbiter_if
//  Description : Classic single-beat Wishbone link. Master drives the request
//                fields; slave returns read data and ack/err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface morty_wb_arbiter_if;
  logic [31:0] addr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output addr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  addr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

`default_nettype wire

// File: rtl/morty_wb_arbiter.sv
// ============================================================================
//  Module      : morty_wb_arbiter
//  Description : Two-master (instruction / data) to one-slave Wishbone classic
//                arbiter. Data port has fixed priority; one transfer per grant.
//                Optional watchdog terminates hung cycles with err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morty_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire                      clk_i,
  input  wire                      rst_i,
  morty_wb_arbiter_if.slave        iwbs,
  morty_wb_arbiter_if.slave        dwbs,
  morty_wb_arbiter_if.master       wbm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t r_state;

  logic w_gnt_i;
  logic w_gnt_d;
  logic w_bus_done;
  logic w_timeout;

  // Reset gates the grants directly so the shared bus drops in the same
  // cycle rst_i rises, independent of when the state register updates.
  assign w_gnt_i    = (r_state == GNT_I) && !rst_i;
  assign w_gnt_d    = (r_state == GNT_D) && !rst_i;
  assign w_bus_done = wbm.ack || wbm.err;

  // Bus watchdog: counts grant cycles without a response; a real ack/err in
  // the final cycle takes precedence over the forced error.
  if (TIMEOUT_CYCLES > 0) begin : g_wdog
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_WDOG_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_wdog_cnt;

    assign w_timeout = (w_gnt_i || w_gnt_d) && (r_wdog_cnt == C_WDOG_LAST) && !w_bus_done;

    // Held at zero outside a grant so every grant starts counting from zero;
    // leaving the grant at the last count means it never wraps.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_wdog_cnt <= '0;
      end else if (r_state == IDLE || w_bus_done || w_timeout) begin
        r_wdog_cnt <= '0;
      end else begin
        r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
    end
  end else begin : g_no_wdog
    assign w_timeout = 1'b0;
  end

  // Arbitration FSM: data wins ties, and any grant returns to IDLE after one
  // response, a timeout, or the granted master abandoning its cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (dwbs.cyc && dwbs.stb) begin
            r_state <= GNT_D;
          end else if (iwbs.cyc && iwbs.stb) begin
            r_state <= GNT_I;
          end
        end
        GNT_I: begin
          if (w_bus_done || w_timeout || !iwbs.cyc) begin
            r_state <= IDLE;
          end
        end
        GNT_D: begin
          if (w_bus_done || w_timeout || !dwbs.cyc) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Shared-port request mux; instruction fetches are always full-word reads.
  always_comb begin
    wbm.addr  = 32'h0;
    wbm.dat_w = 32'h0;
    wbm.sel   = 4'h0;
    wbm.we    = 1'b0;
    wbm.cyc   = 1'b0;
    wbm.stb   = 1'b0;
    if (w_gnt_d) begin
      wbm.addr  = dwbs.addr;
      wbm.dat_w = dwbs.dat_w;
      wbm.sel   = dwbs.sel;
      wbm.we    = dwbs.we;
      wbm.cyc   = dwbs.cyc && !w_timeout;
      wbm.stb   = dwbs.stb && !w_timeout;
    end else if (w_gnt_i) begin
      wbm.addr  = iwbs.addr;
      wbm.sel   = 4'hF;
      wbm.cyc   = iwbs.cyc && !w_timeout;
      wbm.stb   = iwbs.stb && !w_timeout;
    end
  end

  // Responses go only to the granted master; read data is shared and is
  // meaningful only alongside that master's own ack.
  assign iwbs.ack   = w_gnt_i && wbm.ack;
  assign iwbs.err   = w_gnt_i && (wbm.err || w_timeout);
  assign dwbs.ack   = w_gnt_d && wbm.ack;
  assign dwbs.err   = w_gnt_d && (wbm.err || w_timeout);
  assign iwbs.dat_r = wbm.dat_r;
  assign dwbs.dat_r = wbm.dat_r;

endmodule

`default_nettype wire

// File: tb/tb_morty_wb_arbiter.sv
// ============================================================================
//  Module      : tb_morty_wb_arbiter
//  Description : Directed self-checking bench for morty_wb_arbiter
//                (watchdog configured for 8 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morty_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  morty_wb_arbiter_if iwb ();
  morty_wb_arbiter_if dwb ();
  morty_wb_arbiter_if wbm ();

  morty_wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .iwbs  (iwb),
    .dwbs  (dwb),
    .wbm   (wbm)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let inputs be changed safely.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    iwb.addr = 32'h0; iwb.dat_w = 32'h0; iwb.sel = 4'h0; iwb.we = 1'b0;
    iwb.cyc = 1'b0; iwb.stb = 1'b0;
    dwb.addr = 32'h0; dwb.dat_w = 32'h0; dwb.sel = 4'h0; dwb.we = 1'b0;
    dwb.cyc = 1'b0; dwb.stb = 1'b0;
    wbm.dat_r = 32'h0; wbm.ack = 1'b0; wbm.err = 1'b0;

    // Reset state, with a request already pending
    dwb.cyc = 1'b1; dwb.stb = 1'b1;
    settle();
    check("rst_wbm_cyc", {31'h0, wbm.cyc}, 32'h0);
    wbm.ack = 1'b1;
    settle();
    check("rst_dack", {31'h0, dwb.ack}, 32'h0);
    check("rst_iack", {31'h0, iwb.ack}, 32'h0);
    wbm.ack = 1'b0;
    dwb.cyc = 1'b0; dwb.stb = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Test 1: reset pulsed mid-GNT_D
    dwb.addr = 32'h0000_0040; dwb.cyc = 1'b1; dwb.stb = 1'b1;
    tick();
    check("t1_cyc_before", {31'h0, wbm.cyc}, 32'h1);
    rst = 1'b1; wbm.ack = 1'b1;
    settle();
    check("t1_cyc_in_rst", {31'h0, wbm.cyc}, 32'h0);
    check("t1_dack_in_rst", {31'h0, dwb.ack}, 32'h0);
    rst = 1'b0; wbm.ack = 1'b0;
    settle();
    check("t1_idle_after", {31'h0, wbm.cyc}, 32'h0);
    dwb.cyc = 1'b0; dwb.stb = 1'b0;
    tick();

    // Test 2: instruction fetch alone
    iwb.addr = 32'h0000_0100; iwb.cyc = 1'b1; iwb.stb = 1'b1;
    settle();
    check("t2_cyc_at_n", {31'h0, wbm.cyc}, 32'h0);
    tick();
    check("t2_cyc_n1", {31'h0, wbm.cyc}, 32'h1);
    check("t2_addr", wbm.addr, 32'h0000_0100);
    check("t2_sel", {28'h0, wbm.sel}, 32'hF);
    check("t2_we", {31'h0, wbm.we}, 32'h0);
    check("t2_iack_wait", {31'h0, iwb.ack}, 32'h0);
    tick();
    wbm.ack = 1'b1; wbm.dat_r = 32'h0000_0013;
    settle();
    check("t2_iack", {31'h0, iwb.ack}, 32'h1);
    check("t2_idat", iwb.dat_r, 32'h0000_0013);
    check("t2_dack", {31'h0, dwb.ack}, 32'h0);
    tick();
    wbm.ack = 1'b0;
    settle();
    check("t2_idle_gap", {31'h0, wbm.cyc}, 32'h0);
    iwb.cyc = 1'b0; iwb.stb = 1'b0;
    tick();

    // Test 3: simultaneous requests, data store first
    iwb.addr = 32'h0000_0200; iwb.cyc = 1'b1; iwb.stb = 1'b1;
    dwb.addr = 32'h0000_2000; dwb.dat_w = 32'hCAFE_F00D; dwb.sel = 4'h3; dwb.we = 1'b1;
    dwb.cyc = 1'b1; dwb.stb = 1'b1;
    tick();
    check("t3_addr_d", wbm.addr, 32'h0000_2000);
    check("t3_dat_d", wbm.dat_w, 32'hCAFE_F00D);
    check("t3_sel_d", {28'h0, wbm.sel}, 32'h3);
    check("t3_we_d", {31'h0, wbm.we}, 32'h1);
    wbm.ack = 1'b1;
    settle();
    check("t3_dack", {31'h0, dwb.ack}, 32'h1);
    check("t3_iack_blk", {31'h0, iwb.ack}, 32'h0);
    tick();
    wbm.ack = 1'b0;
    dwb.cyc = 1'b0; dwb.stb = 1'b0; dwb.we = 1'b0;
    settle();
    check("t3_idle_gap", {31'h0, wbm.cyc}, 32'h0);
    tick();
    check("t3_addr_i", wbm.addr, 32'h0000_0200);
    check("t3_sel_i", {28'h0, wbm.sel}, 32'hF);
    wbm.ack = 1'b1;
    settle();
    check("t3_iack", {31'h0, iwb.ack}, 32'h1);
    tick();
    wbm.ack = 1'b0;
    iwb.cyc = 1'b0; iwb.stb = 1'b0;
    tick();

    // Test 4: instruction abort with a data request pending
    iwb.addr = 32'h0000_0300; iwb.cyc = 1'b1; iwb.stb = 1'b1;
    tick();
    dwb.addr = 32'h0000_4000; dwb.sel = 4'hF; dwb.cyc = 1'b1; dwb.stb = 1'b1;
    settle();
    check("t4_addr_i", wbm.addr, 32'h0000_0300);
    iwb.cyc = 1'b0; iwb.stb = 1'b0;
    settle();
    check("t4_cyc_drop", {31'h0, wbm.cyc}, 32'h0);
    tick();
    wbm.ack = 1'b1;
    settle();
    check("t4_late_iack", {31'h0, iwb.ack}, 32'h0);
    check("t4_late_dack", {31'h0, dwb.ack}, 32'h0);
    tick();
    wbm.ack = 1'b0;
    settle();
    check("t4_addr_d", wbm.addr, 32'h0000_4000);
    check("t4_cyc_d", {31'h0, wbm.cyc}, 32'h1);
    wbm.ack = 1'b1;
    settle();
    check("t4_dack", {31'h0, dwb.ack}, 32'h1);
    tick();
    wbm.ack = 1'b0;
    dwb.cyc = 1'b0; dwb.stb = 1'b0;
    tick();

    // Test 5a: watchdog fires on the 8th grant cycle
    dwb.addr = 32'h0000_5000; dwb.cyc = 1'b1; dwb.stb = 1'b1;
    tick();
    for (int c = 1; c < 8; c++) begin
      check($sformatf("t5_noerr_c%0d", c), {30'h0, dwb.err, wbm.cyc}, 32'h1);
      tick();
    end
    check("t5_err", {31'h0, dwb.err}, 32'h1);
    check("t5_cyc_forced", {31'h0, wbm.cyc}, 32'h0);
    check("t5_ierr", {31'h0, iwb.err}, 32'h0);
    tick();
    check("t5_err_once", {31'h0, dwb.err}, 32'h0);
    check("t5_idle", {31'h0, wbm.cyc}, 32'h0);
    dwb.cyc = 1'b0; dwb.stb = 1'b0;
    tick();

    // Test 5b: ack on the 8th cycle wins over the timeout
    dwb.cyc = 1'b1; dwb.stb = 1'b1;
    tick();
    for (int c = 1; c < 8; c++) tick();
    wbm.ack = 1'b1;
    settle();
    check("t5b_ack", {31'h0, dwb.ack}, 32'h1);
    check("t5b_noerr", {31'h0, dwb.err}, 32'h0);
    check("t5b_cyc", {31'h0, wbm.cyc}, 32'h1);
    tick();
    wbm.ack = 1'b0;
    dwb.cyc = 1'b0; dwb.stb = 1'b0;
    tick();

    // Test 6: slave err forwarded to instruction master
    iwb.addr = 32'h0000_0600; iwb.cyc = 1'b1; iwb.stb = 1'b1;
    tick();
    wbm.err = 1'b1;
    settle();
    check("t6_ierr", {31'h0, iwb.err}, 32'h1);
    check("t6_iack", {31'h0, iwb.ack}, 32'h0);
    check("t6_derr", {31'h0, dwb.err}, 32'h0);
    tick();
    wbm.err = 1'b0;
    settle();
    check("t6_idle", {31'h0, wbm.cyc}, 32'h0);
    iwb.cyc = 1'b0; iwb.stb = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
